// File: rtl/oh_hs_src.sv
// ---------------------------------------------------------------------------
// oh_hs_src -- source side of a 4-phase req/ack clock-crossing handshake.
//
// Takes one word at a time from a valid/ready producer. The word is held
// on data_out and req_out is raised toward the destination domain. The
// remote acknowledge comes back as ack_in, already synchronized into clk.
// The transfer completes once the full req/ack cycle has returned to zero.
//
// Optional build macro: OH_HS_SRC_TIMEOUT_EN
//   When defined, a transfer that sits in REQ for TIMEOUT cycles without
//   an acknowledge is aborted. Such an abort raises the sticky err flag.
//   When undefined, REQ waits forever, err reads 0 and err_clr is ignored.
//
// Ports
//   clk        clock
//   reset      asynchronous active-high reset
//   in_valid   producer has a word
//   in_data    producer word (DW bits)
//   in_ready   block can accept a word this cycle
//   req_out    handshake request, straight from a flop
//   data_out   captured word, stable while req_out=1
//   ack_in     remote acknowledge, synchronized to clk
//   done       one-cycle pulse on transfer completion
//   busy       handshake in progress (state != IDLE)
//   xfer_count completed transfers, wraps modulo 2^CW
//   err        sticky timeout flag
//   err_clr    clears err (a simultaneous timeout wins)
// ---------------------------------------------------------------------------
module oh_hs_src #(
  parameter int DW      = 32,
  parameter int CW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          req_out,
  output logic [DW-1:0] data_out,
  input  logic          ack_in,
  output logic          done,
  output logic          busy,
  output logic [CW-1:0] xfer_count,
  output logic          err,
  input  logic          err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic            req_reg, req_next;
  logic [DW-1:0]   data_reg, data_next;
  logic            done_reg, done_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            accept;

  // A stale ack left over from the previous handshake must fall before a
  // new word may go out, otherwise the destination could miss a req edge.
  assign in_ready = (state_reg == IDLE) & ~ack_in;
  assign accept   = in_valid & in_ready;
  assign busy     = (state_reg != IDLE);
  assign req_out  = req_reg;
  assign data_out = data_reg;
  assign done     = done_reg;
  assign xfer_count = count_reg;

`ifdef OH_HS_SRC_TIMEOUT_EN
  logic [19:0] tmo_reg, tmo_next;
  logic        err_reg, err_next;
  logic        abort_reg, abort_next;   // current transfer was aborted
  logic        tmo_hit;

  assign tmo_hit = (tmo_reg == 20'(TIMEOUT - 1)) & ~ack_in;
  assign err     = err_reg;
`else
  // err_clr and TIMEOUT have no function in this build.
  logic unused_cfg;
  assign unused_cfg = err_clr ^ (TIMEOUT != 0);
  assign err        = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    count_next = count_reg;
`ifdef OH_HS_SRC_TIMEOUT_EN
    tmo_next   = tmo_reg;
    abort_next = abort_reg;
    // Clear first so that a timeout in the same cycle overrides it.
    err_next   = err_reg & ~err_clr;
`endif

    case (state_reg)
      IDLE: begin
        if (accept) begin
          data_next  = in_data;
          req_next   = 1'b1;
          state_next = REQ;
`ifdef OH_HS_SRC_TIMEOUT_EN
          tmo_next   = 20'd0;
          abort_next = 1'b0;
`endif
        end
      end

      REQ: begin
        // Even an ack already high on entry is only acted on one cycle
        // later, so REQ always lasts at least one cycle.
        if (ack_in) begin
          req_next   = 1'b0;
          state_next = REL;
`ifdef OH_HS_SRC_TIMEOUT_EN
        end else if (tmo_hit) begin
          req_next   = 1'b0;
          state_next = REL;
          err_next   = 1'b1;
          abort_next = 1'b1;
        end else begin
          tmo_next   = tmo_reg + 20'd1;
`endif
        end
      end

      REL: begin
        if (!ack_in) begin
          state_next = IDLE;
`ifdef OH_HS_SRC_TIMEOUT_EN
          abort_next = 1'b0;
          if (!abort_reg) begin
            done_next  = 1'b1;
            count_next = count_reg + 1'b1;
          end
`else
          done_next  = 1'b1;
          count_next = count_reg + 1'b1;
`endif
        end
      end

      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
      count_reg <= count_next;
    end
  end

`ifdef OH_HS_SRC_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_reg   <= 20'd0;
      err_reg   <= 1'b0;
      abort_reg <= 1'b0;
    end else begin
      tmo_reg   <= tmo_next;
      err_reg   <= err_next;
      abort_reg <= abort_next;
    end
  end
`endif

endmodule
